pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, 3, register-address width.
REQ-002 Parameter PC_W, 9, instruction-address width.
REQ-003 Parameter CNT_W, 16, performance-counter width.
REQ-004 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-005 reset  in  1  synchronous, active-low: 0 = reset, sampled on rising clk.
REQ-006 run  in  1  level; host permits free-running execution.
REQ-007 step_req  in  1  single-cycle pulse; host requests one instruction advance.
REQ-008 id_rs1, id_rs2  in  REG_AW  ID-stage source registers.
REQ-009 id_use1, id_use2  in  1  ID instruction reads rs1 / rs2.
REQ-010 ex_wreg  in  REG_AW  EX-stage destination; ex_mem_read in 1 (load); ex_reg_write in 1.
REQ-011 ex_rs1, ex_rs2  in  REG_AW  EX-stage sources, for forwarding.
REQ-012 mem_wreg  in  REG_AW; mem_reg_write  in  1  EX/MEM destination and write flag.
REQ-013 wb_wreg  in  REG_AW; wb_reg_write  in  1  MEM/WB destination and write flag.
REQ-014 br_taken  in  1; br_target  in  PC_W  branch resolved taken in EX, with target.
REQ-015 pc_en, if_id_en, id_ex_en  out  1  stage-register load enables.
REQ-016 if_id_flush, id_ex_flush  out  1  load a bubble (all CTRL fields zero) into the stage register.
REQ-017 pc_sel  out  1; pc_target  out  PC_W  redirect PC to pc_target when pc_sel = 1.
REQ-018 fwd_a, fwd_b  out  2  ALU operand select: 00 register file, 01 EX/MEM, 10 MEM/WB.
REQ-019 halted  out  1; step_ack  out  1 (one-cycle pulse).
REQ-020 stall_cnt, flush_cnt  out  CNT_W  saturating performance counters.

Function
REQ-021 FSM states SHALL be HALT, RUN and STEP, stored in a registered state variable.
- HALT->RUN when run = 1.
- HALT->STEP on step_req when run = 0.
- RUN->HALT when run = 0.
- STEP->HALT after its advance cycle.
REQ-022 In HALT, pc_en, if_id_en and id_ex_en SHALL all be 0, with no flushes; halted SHALL be 1.
REQ-023 Load-use hazard SHALL be: ex_mem_read & ex_reg_write & ((id_use1 & id_rs1 == ex_wreg) | (id_use2 & id_rs2 == ex_wreg)).
REQ-024 On a hazard in RUN/STEP: pc_en = 0, if_id_en = 0, id_ex_en = 1 and id_ex_flush = 1, in the same cycle, for exactly one cycle.
REQ-025 On br_taken in RUN/STEP:
- pc_sel = 1 and pc_target = br_target;
- if_id_flush = 1 and id_ex_flush = 1;
- all enables = 1.
REQ-026 br_taken SHALL take priority over a load-use hazard in the same cycle; that cycle SHALL NOT count as a stall.
REQ-027 Otherwise, in RUN/STEP, all enables SHALL be 1, with no flush and pc_sel = 0.
REQ-028 STEP SHALL persist through stall cycles; it SHALL exit only after the first cycle with pc_en = 1.
REQ-029 step_ack SHALL pulse for one cycle, in the cycle after the STEP advance cycle; step_req is ignored outside HALT.
REQ-030 fwd_a SHALL be combinational and SHALL select:
- 01 if mem_reg_write & mem_wreg == ex_rs1;
- else 10 if wb_reg_write & wb_wreg == ex_rs1;
- else 00.
fwd_b SHALL be identical, using ex_rs2.
REQ-031 stall_cnt SHALL increment on each REQ-024 cycle, and flush_cnt on each REQ-025 cycle; both SHALL saturate at all-ones.
REQ-032 pc_target SHALL equal br_target when pc_sel = 1, and 0 otherwise.

Reset
REQ-033 While reset = 0 on a rising edge:
- state SHALL become HALT;
- counters SHALL become 0;
- step_ack SHALL become 0.
REQ-034 During and after reset, enables SHALL be 0, flushes 0, pc_sel 0, fwd_a/fwd_b 00 and halted 1, until the FSM leaves HALT.
REQ-035 Reset asserted in STEP or RUN SHALL abort that state with no step_ack.

Structure
REQ-036 State encodings and fwd select codes SHALL live in the shared cpu package, alongside the pipeline CTRL field widths.
REQ-037 An optional sub-module sat_counter (width CNT_W, inc, clear) SHALL be instantiated twice; all other logic SHALL be flat.

Verification
REQ-038 Reset low for 2 cycles, then run = 0 -> halted = 1, all enables 0, stall_cnt = flush_cnt = 0.
REQ-039 run = 1, ex_mem_read = ex_reg_write = 1, ex_wreg = 3, id_rs1 = 3, id_use1 = 1 -> one cycle of pc_en = 0 and id_ex_flush = 1; stall_cnt = 1.
REQ-040 br_taken = 1, br_target = 0x1A5, with the same hazard present -> pc_sel = 1, pc_target = 0x1A5, both flushes = 1, stall_cnt unchanged, flush_cnt + 1.
REQ-041 HALT, step_req pulse with a hazard present -> one stall cycle, one advance cycle, step_ack one cycle later, back to HALT.
REQ-042 mem_wreg = wb_wreg = ex_rs1 = 5, with both write flags set -> fwd_a = 01; clear mem_reg_write -> fwd_a = 10.
REQ-043 Force 0xFFFF stall cycles -> stall_cnt holds at 0xFFFF; then reset mid-STEP -> HALT, counters 0, no step_ack.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU definitions: hazard FSM states, forwarding codes,
// and pipeline CTRL field widths / bundle.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int ALU_OP_W = 4;
  localparam int WB_SEL_W = 2;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic [ALU_OP_W-1:0] alu_op;
    logic [WB_SEL_W-1:0] wb_sel;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, clear, inc -> count (holds at all-ones).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/run control: HALT/RUN/STEP, load-use stall, branch flush, forwarding.
// Ports: run/step host ctrl, ID/EX/MEM/WB regs -> enables, flushes, redirect, fwd, counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int PC_W   = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step_req,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_wreg,
  input  logic              wb_reg_write,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              pc_sel,
  output logic [PC_W-1:0]   pc_target,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted,
  output logic              step_ack,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_t state;
  state_t nxt;
  logic   act;
  logic   hazard;
  logic   stall_inc;
  logic   flush_inc;

  function automatic logic [1:0] fwd_pick(
    input logic              m_we,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_we,
    input logic [REG_AW-1:0] w_rd,
    input logic [REG_AW-1:0] rs
  );
    if (m_we && (m_rd == rs))
      return FWD_MEM;
    else if (w_we && (w_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  // Reset input gates outputs too, so the
  // pipeline is frozen while reset is held.
  assign act = reset && (state != HALT);

  assign hazard = ex_mem_read && ex_reg_write &&
    ((id_use1 && (id_rs1 == ex_wreg)) ||
     (id_use2 && (id_rs2 == ex_wreg)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= HALT;
      step_ack <= 1'b0;
    end else begin
      state    <= nxt;
      step_ack <= (state == STEP) && pc_en;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      HALT: begin
        if (run)
          nxt = RUN;
        else if (step_req)
          nxt = STEP;
      end
      RUN: begin
        if (!run)
          nxt = HALT;
      end
      STEP: begin
        if (pc_en)
          nxt = HALT;
      end
      default: nxt = HALT;
    endcase
  end

  // Branch wins over load-use: the stalled
  // instruction is squashed by the flush anyway.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pc_sel      = 1'b0;
    pc_target   = '0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    halted      = !act;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (act) begin
      fwd_a = fwd_pick(mem_reg_write, mem_wreg,
                       wb_reg_write, wb_wreg, ex_rs1);
      fwd_b = fwd_pick(mem_reg_write, mem_wreg,
                       wb_reg_write, wb_wreg, ex_rs2);
      if (br_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        pc_sel      = 1'b1;
        pc_target   = br_target;
        flush_inc   = 1'b1;
      end else if (hazard) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        stall_inc   = 1'b1;
      end else begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (!reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (!reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
